// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one 16-bit saturating CLA adder, with a
// single registered result slot that can be refilled in the cycle it drains.

module adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        padd,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] b_eff;
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] lane_sum;
    logic [3:0]  lane_cin;
    logic [3:0]  lane_cout;
    logic [3:0]  lane_ovf;

    assign b_eff = (sub & ~padd) ? ~b : b;
    assign g     = a & b_eff;
    assign p     = a ^ b_eff;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            localparam int L = 4 * gi;
            logic [3:0] c;
            logic       grp_g;
            logic       grp_p;
            logic [3:0] s;

            // Lanes are isolated in PADDSB mode, otherwise the group carry chains on.
            if (gi == 0) begin : g_cin0
                assign lane_cin[gi] = sub & ~padd;
            end else begin : g_cinn
                assign lane_cin[gi] = ~padd & lane_cout[gi-1];
            end

            assign c[0]  = lane_cin[gi];
            assign c[1]  = g[L] | (p[L] & lane_cin[gi]);
            assign c[2]  = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & lane_cin[gi]);
            assign c[3]  = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                         | (p[L+2] & p[L+1] & p[L] & lane_cin[gi]);
            assign grp_g = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                         | (p[L+3] & p[L+2] & p[L+1] & g[L]);
            assign grp_p = &p[L+3:L];
            assign lane_cout[gi] = grp_g | (grp_p & lane_cin[gi]);

            assign s = p[L+3:L] ^ c;
            // Signed overflow: carry into the lane MSB differs from carry out of it.
            assign lane_ovf[gi] = c[3] ^ lane_cout[gi];
            assign lane_sum[L+3:L] = (padd & lane_ovf[gi]) ? (a[L+3] ? 4'h8 : 4'h7) : s;
        end
    endgenerate

    assign sum  = (~padd & lane_ovf[3]) ? (a[15] ? 16'h8000 : 16'h7FFF) : lane_sum;
    assign cout = ~padd & lane_cout[3];
endmodule

module adder_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_padd,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_padd,
    input  logic        req1_sub,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_sum,
    output logic        rsp_cout,
    input  logic        rsp_ready
);
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [15:0] rsp_sum_q, rsp_sum_d;
    logic        rsp_cout_q, rsp_cout_d;
    logic        last_grant_q, last_grant_d;

    logic        slot_free;
    logic        grant;
    logic        fire;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_padd;
    logic        op_sub;
    logic [15:0] add_sum;
    logic        add_cout;

    assign slot_free = ~rsp_valid_q | rsp_ready;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = RR_EN ? ~last_grant_q : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = slot_free & req0_valid & ~grant;
    assign req1_ready = slot_free & req1_valid & grant;
    assign fire       = req0_ready | req1_ready;

    assign op_a    = grant ? req1_a    : req0_a;
    assign op_b    = grant ? req1_b    : req0_b;
    assign op_padd = grant ? req1_padd : req0_padd;
    assign op_sub  = grant ? req1_sub  : req0_sub;

    adder16 u_adder (
        .a    (op_a),
        .b    (op_b),
        .padd (op_padd),
        .sub  (op_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        last_grant_d = last_grant_q;
        if (fire) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant;
            rsp_sum_d    = add_sum;
            rsp_cout_d   = add_cout;
            last_grant_d = grant;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= 16'h0000;
            rsp_cout_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
endmodule
